alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised execute block: register file (2 read, 1 write), reg/imm operand select, and a
//  multi-op ALU with a registered result. An iterative shift-add multiplier is added behind a
//  valid/ready issue handshake. Sits between decode and the branch/PC logic: drives ALUout, EQ and a0.
// PARAMETERS
//  ADDRESS_WIDTH  5   register index width; 2**ADDRESS_WIDTH registers; must be >=4 (a0 = x10)
//  DATA_WIDTH     32  datapath / register width; power of two, >=8
//  MUL_EN         1   1: op 4'hA is an iterative multiply; 0: op 4'hA is reserved
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  in_valid   in   1              instruction presented on the issue inputs
//  in_ready   out  1              unit can accept an instruction this cycle
//  RegWrite   in   1              write the result to rd
//  ALUsrc     in   1              0: op2 = reg[rs2]; 1: op2 = immOp
//  ALUctrl    in   4              operation select (see BEHAVIOUR)
//  immOp      in   DATA_WIDTH     sign-extended immediate
//  rs1,rs2,rd in   ADDRESS_WIDTH  source/destination register indices
//  ALUout     out  DATA_WIDTH     registered result of the last completed instruction
//  EQ         out  1              registered: op1 == op2 of the last completed instruction
//  out_valid  out  1              one-cycle pulse: ALUout/EQ updated, write-back done
//  a0         out  DATA_WIDTH     combinational read of reg[10]
// BEHAVIOUR
//  - Reset: all registers 0; ALUout=0, EQ=0, out_valid=0; FSM in IDLE (in_ready=1).
//    Reset wins over every other event. An in-flight multiply is aborted with no write and no pulse.
//  - Accept = in_valid & in_ready. Inputs are sampled only on acceptance; they are ignored otherwise.
//  - Operands: op1 = reg[rs1]; op2 = ALUsrc ? immOp : reg[rs2]. reg[0] always reads 0.
//  - ALUctrl: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA,
//    A MUL (low DATA_WIDTH bits of the product), B-F reserved: result 0.
//  - Arithmetic wraps modulo 2**DATA_WIDTH. Shifts use op2[$clog2(DATA_WIDTH)-1:0] only.
//    SLT/SLTU produce 0 or 1 in bit 0.
//  - FSM IDLE (in_ready=1):
//    - Accept of a non-MUL op: at that edge, ALUout<=result, EQ<=(op1==op2), and reg[rd]<=result
//      when RegWrite & rd!=0. out_valid=1 in the next cycle only. Latency 1; throughput 1/cycle.
//    - Consecutive instructions see the previous write (the write occurs at the accept edge).
//    - Accept of MUL with MUL_EN=1: latch op1, op2, rd, RegWrite, and EQ_pending=(op1==op2);
//      clear accumulator; counter=0; go to BUSY. With MUL_EN=0, MUL is treated as reserved.
//  - FSM BUSY (in_ready=0): one multiplier bit per cycle (LSB first, add shifted op1 if bit set).
//    counter counts 0..DATA_WIDTH-1. On the edge where counter==DATA_WIDTH-1: ALUout<=product,
//    EQ<=EQ_pending, optional write to rd (rd!=0), return to IDLE.
//    out_valid and in_ready are both high in the following cycle.
//    Acceptance edge to out_valid = DATA_WIDTH+1 cycles. ALUout/EQ hold their old values while BUSY.
//  - Writes to x0 are dropped silently. With RegWrite=0, ALUout/EQ/out_valid still update.
//  - a0 reflects a write to x10 in the cycle after the writing edge.
//  - ALUout, EQ and a0 are undefined-free: never X after reset.
// TESTING
//  1 rst; ADD rd=10 rs1=0 imm=5 ALUsrc=1 -> next cycle out_valid=1, ALUout=5, a0=5
//  2 x1=7, x2=7; SUB rd=3 rs1=1 rs2=2 -> ALUout=0, EQ=1; SLT with x1=-1, x2=1 -> 1; SLTU -> 0
//  3 ADD rd=0 imm=9 RegWrite=1 -> ALUout=9, reg[0] still reads 0; SRA 0x80000000 by imm 0x21 -> 0xC0000000
//  4 MUL x1=-3, x2=5 -> in_ready=0 for 32 cycles; out_valid at cycle 33, ALUout=0xFFFFFFF1
//    (check at cycle 33 from the acceptance edge); in_valid held high throughout is not accepted
//  5 MUL started, rst asserted at busy cycle 10 -> next cycle in_ready=1, out_valid=0, rd unchanged
//  6 back-to-back ADD x5=x0+1 then ADD x6=x5+x5 on consecutive cycles -> second ALUout=2

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute unit: 2R/1W register file, operand select, ALU, iterative multiplier
module alu_exec_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter bit MUL_EN        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     RegWrite,
    input  logic                     ALUsrc,
    input  logic [3:0]               ALUctrl,
    input  logic [DATA_WIDTH-1:0]    immOp,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ALUout,
    output logic                     EQ,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0]    regs [NREG];
    logic [DATA_WIDTH-1:0]    op1, op2, result;
    logic [SHW-1:0]           shamt;
    logic                     accept, is_mul;

    logic [DATA_WIDTH-1:0]    mul_mcand, mul_mplier, mul_acc, mul_sum;
    logic [SHW-1:0]           mul_cnt;
    logic [ADDRESS_WIDTH-1:0] mul_rd;
    logic                     mul_we, eq_pending;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mul   = MUL_EN && (ALUctrl == 4'hA);
    assign a0       = regs[10];

    assign op1   = (rs1 == '0) ? '0 : regs[rs1];
    assign op2   = ALUsrc ? immOp : ((rs2 == '0) ? '0 : regs[rs2]);
    assign shamt = op2[SHW-1:0];

    always_comb begin
        result = '0;
        case (ALUctrl)
            4'h0: result = op1 + op2;
            4'h1: result = op1 - op2;
            4'h2: result = op1 & op2;
            4'h3: result = op1 | op2;
            4'h4: result = op1 ^ op2;
            4'h5: result = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'h6: result = {{(DATA_WIDTH-1){1'b0}}, op1 < op2};
            4'h7: result = op1 << shamt;
            4'h8: result = op1 >> shamt;
            4'h9: result = $unsigned($signed(op1) >>> shamt);
            default: result = '0;
        endcase
    end

    // Shift-add step: multiplicand moves left while the multiplier is consumed LSB first.
    assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept && is_mul) state_n = S_BUSY;
            S_BUSY: if (mul_cnt == CNT_LAST) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            ALUout     <= '0;
            EQ         <= 1'b0;
            out_valid  <= 1'b0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
            mul_rd     <= '0;
            mul_we     <= 1'b0;
            eq_pending <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && is_mul) begin
                    mul_mcand  <= op1;
                    mul_mplier <= op2;
                    mul_acc    <= '0;
                    mul_cnt    <= '0;
                    mul_rd     <= rd;
                    mul_we     <= RegWrite;
                    eq_pending <= (op1 == op2);
                end else if (accept) begin
                    ALUout    <= result;
                    EQ        <= (op1 == op2);
                    out_valid <= 1'b1;
                    if (RegWrite && rd != '0) regs[rd] <= result;
                end
            end else begin
                mul_acc    <= mul_sum;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
                if (mul_cnt == CNT_LAST) begin
                    ALUout    <= mul_sum;
                    EQ        <= eq_pending;
                    out_valid <= 1'b1;
                    if (mul_we && mul_rd != '0) regs[mul_rd] <= mul_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit with a result scoreboard
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, RegWrite, ALUsrc, EQ, out_valid;
    logic [3:0]  ALUctrl;
    logic [31:0] immOp, ALUout, a0;
    logic [4:0]  rs1, rs2, rd;

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb [$];
    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    alu_exec_unit #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .immOp(immOp),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ALUout(ALUout), .EQ(EQ),
        .out_valid(out_valid), .a0(a0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(b[4:0]);
        case (c)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'h6: return (a < b) ? 32'd1 : 32'd0;
            4'h7: return a << sa;
            4'h8: return a >> sa;
            4'h9: return a[31] ? ~((~a) >> sa) : (a >> sa);
            4'hA: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : mregs[i];
    endfunction

    // Scoreboard: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            logic [32:0] e;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected_pulse observed=%h expected=no_pulse", ALUout);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_aluout", ALUout, e[31:0]);
                chk("sb_eq", {31'd0, EQ}, {31'd0, e[32]});
            end
        end
    end

    task automatic issue(input logic rw, input logic src, input logic [3:0] c, input logic [31:0] imm,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        logic [31:0] a, b, r;
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", {31'd0, in_ready}, 32'd1);
        a = rdm(r1);
        b = src ? imm : rdm(r2);
        r = ref_alu(c, a, b);
        sb.push_back({a == b, r});
        if (rw && d != 5'd0) mregs[d] = r;
        RegWrite = rw; ALUsrc = src; ALUctrl = c; immOp = imm;
        rs1 = r1; rs2 = r2; rd = d; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int n;
        rst = 1'b1; in_valid = 1'b0; RegWrite = 1'b0; ALUsrc = 1'b0; ALUctrl = 4'h0;
        immOp = 32'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_aluout", ALUout, 32'd0);
        chk("rst_eq", {31'd0, EQ}, 32'd0);
        chk("rst_a0", a0, 32'd0);
        rst = 1'b0;

        // ADD into a0
        issue(1'b1, 1'b1, 4'h0, 32'd5, 5'd0, 5'd0, 5'd10);
        @(negedge clk);
        chk("add_a0_valid", {31'd0, out_valid}, 32'd1);
        chk("add_a0_aluout", ALUout, 32'd5);
        chk("add_a0_a0", a0, 32'd5);

        // SUB of equal registers, SLT / SLTU with -1 vs 1
        issue(1'b1, 1'b1, 4'h0, 32'd7, 5'd0, 5'd0, 5'd1);
        issue(1'b1, 1'b1, 4'h0, 32'd7, 5'd0, 5'd0, 5'd2);
        issue(1'b1, 1'b0, 4'h1, 32'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("sub_aluout", ALUout, 32'd0);
        chk("sub_eq", {31'd0, EQ}, 32'd1);
        issue(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd1);
        issue(1'b1, 1'b1, 4'h0, 32'd1, 5'd0, 5'd0, 5'd2);
        issue(1'b1, 1'b0, 4'h5, 32'd0, 5'd1, 5'd2, 5'd4);
        @(negedge clk);
        chk("slt_aluout", ALUout, 32'd1);
        issue(1'b1, 1'b0, 4'h6, 32'd0, 5'd1, 5'd2, 5'd4);
        @(negedge clk);
        chk("sltu_aluout", ALUout, 32'd0);

        // Write to x0 is dropped; SRA uses only the low shift bits
        issue(1'b1, 1'b1, 4'h0, 32'd9, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("x0_write_aluout", ALUout, 32'd9);
        issue(1'b1, 1'b0, 4'h0, 32'd0, 5'd0, 5'd0, 5'd13);
        @(negedge clk);
        chk("x0_read_zero", ALUout, 32'd0);
        issue(1'b1, 1'b1, 4'h0, 32'h8000_0000, 5'd0, 5'd0, 5'd1);
        issue(1'b1, 1'b1, 4'h9, 32'h21, 5'd1, 5'd0, 5'd14);
        @(negedge clk);
        chk("sra_aluout", ALUout, 32'hC000_0000);
        issue(1'b0, 1'b1, 4'hB, 32'h1234, 5'd1, 5'd0, 5'd15);

        // MUL -3 * 5 with a competing instruction held on the inputs
        issue(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFD, 5'd0, 5'd0, 5'd1);
        issue(1'b1, 1'b1, 4'h0, 32'd5, 5'd0, 5'd0, 5'd2);
        @(negedge clk);
        a = rdm(5'd1); b = rdm(5'd2);
        sb.push_back({a == b, a * b});
        mregs[9] = a * b;
        RegWrite = 1'b1; ALUsrc = 1'b0; ALUctrl = 4'hA; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1 ALUctrl = 4'h0; ALUsrc = 1'b1; immOp = 32'h55; rd = 5'd10;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k <= 32) begin
                chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
                chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
                chk("mul_busy_hold", ALUout, 32'd5);
            end else begin
                chk("mul_done_ready", {31'd0, in_ready}, 32'd1);
                chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
                chk("mul_done_aluout", ALUout, 32'hFFFF_FFF1);
                in_valid = 1'b0;
            end
        end
        chk("mul_a0_untouched", a0, 32'd5);
        issue(1'b1, 1'b0, 4'h0, 32'd0, 5'd9, 5'd0, 5'd11);

        // Reset during a multiply aborts it
        issue(1'b1, 1'b1, 4'h0, 32'd6, 5'd0, 5'd0, 5'd7);
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        RegWrite = 1'b1; ALUsrc = 1'b0; ALUctrl = 4'hA; rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_a0", a0, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort_no_pulse", {31'd0, out_valid}, 32'd0);
        end
        issue(1'b1, 1'b1, 4'h0, 32'd0, 5'd7, 5'd0, 5'd8);
        @(negedge clk);
        chk("abort_rd_unchanged", ALUout, 32'd0);

        // Back-to-back dependent ADDs
        issue(1'b1, 1'b1, 4'h0, 32'd1, 5'd0, 5'd0, 5'd5);
        issue(1'b1, 1'b0, 4'h0, 32'd0, 5'd5, 5'd5, 5'd6);
        @(negedge clk);
        chk("b2b_aluout", ALUout, 32'd2);

        // Mixed random traffic against the model
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  $urandom(), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
